rpc2_ctrl_status_sync: RTL and testbench



---
 rtl/rpc2_ctrl_pkg.sv | 27 ++
 rtl/rpc2_ctrl_sync_bit.sv | 31 +++
 rtl/rpc2_ctrl_status_sync.sv | 81 ++++++++
 tb/tb_rpc2_ctrl_status_sync.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rpc2_ctrl_pkg.sv
// Shared constants for the RPC2 controller status path: synchronizer depth
// limits, default channel count, status channel indices and event rule.
package rpc2_ctrl_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int NUM_CH_DEFAULT  = 9;

  typedef enum int unsigned {
    RD_ACTIVE = 0,
    WR_ACTIVE = 1,
    WR_RSTO   = 2,
    WR_SLV    = 3,
    WR_DEC    = 4,
    RD_STALL  = 5,
    RD_RSTO   = 6,
    RD_SLV    = 7,
    RD_DEC    = 8
  } rpc2_status_ch_e;

  // Toggle-encoded sources signal an event on any change, level sources on a rise.
  function automatic logic detect_event(input logic toggle, input logic newer,
                                        input logic older);
    return toggle ? (newer ^ older) : (newer & ~older);
  endfunction

endpackage

// File: rtl/rpc2_ctrl_sync_bit.sv
// One-bit multi-flop synchronizer; exposes the last two stages so the
// caller can detect edges on already-settled data.
module rpc2_ctrl_sync_bit
  import rpc2_ctrl_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic AXIr_ACLK,
  input  logic AXIr_ARESETN,
  input  logic i_async,
  output logic o_stage_prev,
  output logic o_stage_last
);

  // Out-of-range depths are clamped into the supported window.
  localparam int STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
                          (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX :
                          SYNC_STAGES;

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge AXIr_ACLK or negedge AXIr_ARESETN) begin
    if (!AXIr_ARESETN) r_chain <= {STAGES{RESET_VAL}};
    else               r_chain <= {r_chain[STAGES-2:0], i_async};
  end

  assign o_stage_prev = r_chain[STAGES-2];
  assign o_stage_last = r_chain[STAGES-1];

endmodule

// File: rtl/rpc2_ctrl_status_sync.sv
// Multi-channel status synchronizer: per-channel event capture, W1C sticky
// bits, saturating event counters and a masked registered interrupt.
module rpc2_ctrl_status_sync
  import rpc2_ctrl_pkg::*;
#(
  parameter int              NUM_CH      = NUM_CH_DEFAULT,
  parameter int              SYNC_STAGES = 2,
  parameter logic [NUM_CH-1:0] TOGGLE_MASK = '0,
  parameter logic [NUM_CH-1:0] RESET_VAL   = '0,
  parameter int              CNT_W       = 8
) (
  input  logic                    AXIr_ACLK,
  input  logic                    AXIr_ARESETN,
  input  logic [NUM_CH-1:0]       async_in,
  output logic [NUM_CH-1:0]       sync_out,
  output logic [NUM_CH-1:0]       event_pulse,
  output logic [NUM_CH-1:0]       sticky,
  input  logic                    clr_we,
  input  logic [NUM_CH-1:0]       clr_data,
  input  logic [NUM_CH-1:0]       cnt_clr,
  input  logic [NUM_CH-1:0]       irq_en,
  output logic [NUM_CH*CNT_W-1:0] event_cnt,
  output logic                    irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_CH-1:0] w_prev;
  logic [NUM_CH-1:0] w_last;
  logic [NUM_CH-1:0] w_event;
  logic [NUM_CH-1:0] w_clr_mask;
  logic [NUM_CH-1:0] r_event_pulse;
  logic [NUM_CH-1:0] r_sticky;
  logic              r_irq;
  logic [CNT_W-1:0]  r_cnt [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    rpc2_ctrl_sync_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VAL   (RESET_VAL[g])
    ) u_sync (
      .AXIr_ACLK    (AXIr_ACLK),
      .AXIr_ARESETN (AXIr_ARESETN),
      .i_async      (async_in[g]),
      .o_stage_prev (w_prev[g]),
      .o_stage_last (w_last[g])
    );

    assign w_event[g] = detect_event(TOGGLE_MASK[g], w_prev[g], w_last[g]);

    // A clear coinciding with an event keeps that event in the count.
    always_ff @(posedge AXIr_ACLK or negedge AXIr_ARESETN) begin
      if (!AXIr_ARESETN)                           r_cnt[g] <= '0;
      else if (cnt_clr[g])                         r_cnt[g] <= r_event_pulse[g] ? CNT_W'(1) : '0;
      else if (r_event_pulse[g] && r_cnt[g] != CNT_MAX) r_cnt[g] <= r_cnt[g] + CNT_W'(1);
    end

    assign event_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
  end

  assign w_clr_mask = clr_data & {NUM_CH{clr_we}};

  // Set wins over a same-cycle W1C clear.
  always_ff @(posedge AXIr_ACLK or negedge AXIr_ARESETN) begin
    if (!AXIr_ARESETN) begin
      r_event_pulse <= '0;
      r_sticky      <= '0;
      r_irq         <= 1'b0;
    end else begin
      r_event_pulse <= w_event;
      r_sticky      <= (r_sticky & ~w_clr_mask) | r_event_pulse;
      r_irq         <= |(r_sticky & irq_en);
    end
  end

  assign sync_out    = w_last;
  assign event_pulse = r_event_pulse;
  assign sticky      = r_sticky;
  assign irq         = r_irq;

endmodule

// File: tb/tb_rpc2_ctrl_status_sync.sv
// Bench for rpc2_ctrl_status_sync: directed scenarios plus random traffic,
// all compared each cycle against a delay-line reference model.
module tb_rpc2_ctrl_status_sync;

  localparam int              NUM_CH = 9;
  localparam int              S      = 3;
  localparam int              CNT_W  = 2;
  localparam logic [NUM_CH-1:0] TM   = 9'h020;
  localparam logic [NUM_CH-1:0] RV   = 9'h004;
  localparam int              CMAX   = (1 << CNT_W) - 1;

  logic                    AXIr_ACLK = 1'b0;
  logic                    AXIr_ARESETN;
  logic [NUM_CH-1:0]       async_in;
  logic [NUM_CH-1:0]       sync_out;
  logic [NUM_CH-1:0]       event_pulse;
  logic [NUM_CH-1:0]       sticky;
  logic                    clr_we;
  logic [NUM_CH-1:0]       clr_data;
  logic [NUM_CH-1:0]       cnt_clr;
  logic [NUM_CH-1:0]       irq_en;
  logic [NUM_CH*CNT_W-1:0] event_cnt;
  logic                    irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 AXIr_ACLK = ~AXIr_ACLK;

  rpc2_ctrl_status_sync #(
    .NUM_CH      (NUM_CH),
    .SYNC_STAGES (S),
    .TOGGLE_MASK (TM),
    .RESET_VAL   (RV),
    .CNT_W       (CNT_W)
  ) dut (
    .AXIr_ACLK    (AXIr_ACLK),
    .AXIr_ARESETN (AXIr_ARESETN),
    .async_in     (async_in),
    .sync_out     (sync_out),
    .event_pulse  (event_pulse),
    .sticky       (sticky),
    .clr_we       (clr_we),
    .clr_data     (clr_data),
    .cnt_clr      (cnt_clr),
    .irq_en       (irq_en),
    .event_cnt    (event_cnt),
    .irq          (irq)
  );

  // Reference: m_hist[k] is async_in as sampled k+1 edges ago.
  logic [NUM_CH-1:0] m_hist [S];
  logic [NUM_CH-1:0] m_ev;
  logic [NUM_CH-1:0] m_sticky;
  logic              m_irq;
  int                m_cnt [NUM_CH];

  always @(posedge AXIr_ACLK or negedge AXIr_ARESETN) begin
    if (!AXIr_ARESETN) begin
      for (int k = 0; k < S; k++) m_hist[k] <= RV;
      m_ev     <= '0;
      m_sticky <= '0;
      m_irq    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) m_cnt[i] <= 0;
    end else begin
      m_hist[0] <= async_in;
      for (int k = 1; k < S; k++) m_hist[k] <= m_hist[k-1];
      for (int i = 0; i < NUM_CH; i++) begin
        if (TM[i]) m_ev[i] <= m_hist[S-2][i] != m_hist[S-1][i];
        else       m_ev[i] <= m_hist[S-2][i] && !m_hist[S-1][i];
        if (cnt_clr[i])  m_cnt[i] <= m_ev[i] ? 1 : 0;
        else if (m_ev[i]) m_cnt[i] <= (m_cnt[i] + 1 > CMAX) ? CMAX : m_cnt[i] + 1;
      end
      m_sticky <= (clr_we ? (m_sticky & ~clr_data) : m_sticky) | m_ev;
      m_irq    <= (m_sticky & irq_en) != '0;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int cnt_of(input int ch);
    return int'(event_cnt[ch*CNT_W +: CNT_W]);
  endfunction

  task automatic compare_model();
    logic [NUM_CH*CNT_W-1:0] exp_cnt;
    for (int i = 0; i < NUM_CH; i++) exp_cnt[i*CNT_W +: CNT_W] = m_cnt[i][CNT_W-1:0];
    check_eq("sync_out",    64'(sync_out),    64'(m_hist[S-1]));
    check_eq("event_pulse", 64'(event_pulse), 64'(m_ev));
    check_eq("sticky",      64'(sticky),      64'(m_sticky));
    check_eq("event_cnt",   64'(event_cnt),   64'(exp_cnt));
    check_eq("irq",         64'(irq),         64'(m_irq));
  endtask

  task automatic tick(input int n = 1);
    for (int c = 0; c < n; c++) begin
      @(negedge AXIr_ACLK);
      compare_model();
    end
  endtask

  initial begin
    AXIr_ARESETN = 1'b0;
    async_in = RV;
    clr_we = 1'b0; clr_data = '0; cnt_clr = '0; irq_en = '0;
    repeat (3) @(negedge AXIr_ACLK);
    AXIr_ARESETN = 1'b1;

    // Quiet after reset with inputs at their reset value.
    tick(10);
    check_eq("rst_sync",  64'(sync_out), 64'(9'h004));
    check_eq("rst_event", 64'(event_pulse), 64'd0);
    check_eq("rst_irq",   64'(irq), 64'd0);

    // Level rise on channel 0.
    irq_en = '1;
    async_in[0] = 1'b1;
    tick(3);
    check_eq("lvl_sync_e3",  64'(sync_out[0]), 64'd1);
    check_eq("lvl_pulse_e3", 64'(event_pulse[0]), 64'd1);
    tick(1);
    check_eq("lvl_sticky_e4", 64'(sticky[0]), 64'd1);
    check_eq("lvl_pulse_e4",  64'(event_pulse[0]), 64'd0);
    check_eq("lvl_cnt_e4",    64'(cnt_of(0)), 64'd1);
    tick(1);
    check_eq("lvl_irq_e5", 64'(irq), 64'd1);

    // Toggle channel 5: three changes including a falling one.
    for (int t = 0; t < 3; t++) begin
      async_in[5] = ~async_in[5];
      tick(4);
    end
    tick(2);
    check_eq("tgl_cnt", 64'(cnt_of(5)), 64'd3);

    // Sticky set beats same-cycle clear, then a lone clear drops irq a cycle later.
    irq_en = 9'h001;
    async_in[0] = 1'b0;
    tick(4);
    clr_we = 1'b1; clr_data = '1;
    tick(1);
    clr_we = 1'b0; clr_data = '0;
    async_in[0] = 1'b1;
    tick(3);
    clr_we = 1'b1; clr_data = 9'h001;
    tick(1);
    check_eq("set_wins_sticky", 64'(sticky[0]), 64'd1);
    clr_we = 1'b0; clr_data = '0;
    tick(1);
    clr_we = 1'b1; clr_data = 9'h001;
    tick(1);
    check_eq("clr_sticky", 64'(sticky[0]), 64'd0);
    check_eq("clr_irq_k",  64'(irq), 64'd1);
    clr_we = 1'b0; clr_data = '0;
    tick(1);
    check_eq("clr_irq_k1", 64'(irq), 64'd0);

    // Counter saturation on channel 1, then clear with a coincident event.
    for (int e = 0; e < 5; e++) begin
      async_in[1] = 1'b1; tick(4);
      async_in[1] = 1'b0; tick(4);
    end
    check_eq("sat_cnt", 64'(cnt_of(1)), 64'(CMAX));
    async_in[1] = 1'b1;
    tick(3);
    cnt_clr[1] = 1'b1;
    tick(1);
    cnt_clr[1] = 1'b0;
    check_eq("clr_evt_cnt", 64'(cnt_of(1)), 64'd1);
    async_in[1] = 1'b0;
    tick(4);

    // Reset between stage edges while an event is in flight.
    async_in[3] = 1'b1;
    tick(1);
    #2;
    AXIr_ARESETN = 1'b0;
    #1;
    check_eq("mid_rst_sync",   64'(sync_out), 64'(RV));
    check_eq("mid_rst_event",  64'(event_pulse), 64'd0);
    check_eq("mid_rst_sticky", 64'(sticky), 64'd0);
    check_eq("mid_rst_cnt",    64'(event_cnt), 64'd0);
    check_eq("mid_rst_irq",    64'(irq), 64'd0);
    async_in = RV;
    tick(2);
    AXIr_ARESETN = 1'b1;
    tick(6);
    check_eq("post_rst_sticky", 64'(sticky), 64'd0);

    // Random traffic, inputs held long enough to satisfy source constraints.
    for (int it = 0; it < 250; it++) begin
      int hold;
      async_in = NUM_CH'($urandom);
      hold = $urandom_range(4, 7);
      for (int c = 0; c < hold; c++) begin
        clr_we   = ($urandom_range(0, 3) == 0);
        clr_data = NUM_CH'($urandom);
        cnt_clr  = ($urandom_range(0, 7) == 0) ? NUM_CH'($urandom) : '0;
        if ($urandom_range(0, 5) == 0) irq_en = NUM_CH'($urandom);
        tick(1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
